spi_reg_host: RTL

- SPI master that issues single register read/write transactions to the modem's SPI-slave control register file: 1000 RAM bytes at 0-999, control registers at 1000-1023.
- Used by the bench host model, and by a future on-board supervisor, to load message RAM, set the message length and kick transmit.
- Takes a parallel request, serialises a 24-bit frame on SCLK/SSN/MOSI, and returns the read byte from MISO.

---
 rtl/spi_reg_host.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_host.sv
// spi_reg_host: SPI mode-0 master for single register read/write frames
// to the modem control register file (24-bit frame: W, 5'b0, addr[9:0], data[7:0]).
// Optional feature macro: SPI_REG_HOST_TXPOLL_EN. When it is defined, a write of
// bit0=1 to address 1023 is followed by autonomous read polls of 1023 until bit0
// reads back 0, and the o_tx_complete output is added.
module spi_reg_host #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_HALVES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic       i_write,
  input  logic [9:0] i_addr,
  input  logic [7:0] i_wdata,
  input  logic       i_miso,
  output logic       o_sclk,
  output logic       o_ssn,
  output logic       o_mosi,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rdata
`ifdef SPI_REG_HOST_TXPOLL_EN
  ,
  output logic       o_tx_complete
`endif
);

  localparam int unsigned DIV_W   = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam int unsigned FRAME_W = 24;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0] BIT_LAST = 5'(FRAME_W - 1);
  localparam logic [4:0] GAP_LAST = 5'(GAP_HALVES - 1);
  localparam logic [4:0] DATA_BITS = 5'd8;

  // Reject divider/gap settings the counters cannot represent
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_reg_host: CLK_DIV must be at least 2");
  end
  if ((GAP_HALVES < 1) || (GAP_HALVES > 32)) begin : g_bad_gap
    $error("spi_reg_host: GAP_HALVES must be in 1..32");
  end

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic [22:0]      tx_sh;    // frame bits still to be driven after the current one
  logic [7:0]       rx_sh;
  logic             is_write;
  logic             div_end_c;

`ifdef SPI_REG_HOST_TXPOLL_EN
  localparam logic [9:0] POLL_ADDR = 10'd1023;
  logic poll_arm;             // current write kicks transmit
  logic polling;              // current read is a transmit-status poll
  logic poll_next_c;

  // Another status poll follows a kicking write, or a poll that still reads busy
  assign poll_next_c = (is_write && poll_arm) || (!is_write && polling && rx_sh[0]);
`endif

  assign div_end_c = (div_cnt == DIV_LAST);

  // Frame sequencer: divider, bit counter, shift registers and all outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      is_write <= 1'b0;
      o_sclk   <= 1'b0;
      o_ssn    <= 1'b1;
      o_mosi   <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      // An aborted frame keeps the last read byte; a reset seen while idle clears it
      if (state == IDLE) o_rdata <= 8'h00;
`ifdef SPI_REG_HOST_TXPOLL_EN
      poll_arm      <= 1'b0;
      polling       <= 1'b0;
      o_tx_complete <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
`ifdef SPI_REG_HOST_TXPOLL_EN
      o_tx_complete <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (i_start) begin
            state    <= SETUP;
            div_cnt  <= '0;
            is_write <= i_write;
            tx_sh    <= {5'b0, i_addr, (i_write ? i_wdata : 8'h00)};
            o_mosi   <= i_write;
            o_ssn    <= 1'b0;
            o_sclk   <= 1'b0;
            o_busy   <= 1'b1;
`ifdef SPI_REG_HOST_TXPOLL_EN
            poll_arm <= i_write && (i_addr == POLL_ADDR) && i_wdata[0];
            polling  <= 1'b0;
`endif
          end
        end

        SETUP: begin
          if (div_end_c) begin
            state   <= SHIFT;
            div_cnt <= '0;
            bit_cnt <= BIT_LAST;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        SHIFT: begin
          if (div_end_c) begin
            div_cnt <= '0;
            if (!o_sclk) begin
              o_sclk <= 1'b1;
              if (bit_cnt < DATA_BITS) rx_sh <= {rx_sh[6:0], i_miso};
            end else begin
              o_sclk <= 1'b0;
              if (bit_cnt == 5'd0) begin
                state  <= HOLD;
                o_mosi <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt - 5'd1;
                o_mosi  <= tx_sh[22];
                tx_sh   <= {tx_sh[21:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        HOLD: begin
          if (div_end_c) begin
            state   <= GAP;
            div_cnt <= '0;
            bit_cnt <= GAP_LAST;
            o_ssn   <= 1'b1;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        GAP: begin
          if (div_end_c) begin
            div_cnt <= '0;
            if (bit_cnt != 5'd0) begin
              bit_cnt <= bit_cnt - 5'd1;
            end else
`ifdef SPI_REG_HOST_TXPOLL_EN
            if (poll_next_c) begin
              state    <= SETUP;
              is_write <= 1'b0;
              poll_arm <= 1'b0;
              polling  <= 1'b1;
              tx_sh    <= {5'b0, POLL_ADDR, 8'h00};
              o_mosi   <= 1'b0;
              o_ssn    <= 1'b0;
            end else
`endif
            begin
              state  <= IDLE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
              if (!is_write) o_rdata <= rx_sh;
`ifdef SPI_REG_HOST_TXPOLL_EN
              o_tx_complete <= polling;
              polling       <= 1'b0;
              poll_arm      <= 1'b0;
`endif
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
